// File: rtl/c64_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c64_bus_pkg
// Description : Shared types and memory-map constants for the C64 bus side.
// Revision    : 1.0 - initial release
// ============================================================================
package c64_bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM    = 3'd0,
        REG_BASIC  = 3'd1,
        REG_KERNAL = 3'd2,
        REG_CHAR   = 3'd3,
        REG_IO     = 3'd4
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] c_basic_base  = 16'hA000;
    localparam logic [15:0] c_basic_end   = 16'hC000;
    localparam logic [15:0] c_io_base     = 16'hD000;
    localparam logic [15:0] c_kernal_base = 16'hE000;

endpackage
`default_nettype wire

// File: rtl/c64_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : c64_bus_responder_if
// Description : CPU, external-memory and I/O signals of the bus responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface c64_bus_responder_if;
    logic [15:0] ab;
    logic        we;
    logic [7:0]  dout;
    logic [2:0]  po;
    logic        ext_rdy;
    logic [7:0]  din;
    logic        rdy;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        io_cs;
    logic        io_we;
    logic [11:0] io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;

    modport slave (
        input  ab, we, dout, po, ext_rdy, mem_ack, mem_rdata, io_rdata,
        output din, rdy, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
               io_cs, io_we, io_addr, io_wdata
    );

    modport master (
        output ab, we, dout, po, ext_rdy, mem_ack, mem_rdata, io_rdata,
        input  din, rdy, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
               io_cs, io_we, io_addr, io_wdata
    );
endinterface
`default_nettype wire

// File: rtl/c64_pla_decode.sv
`default_nettype none
// ============================================================================
// Module      : c64_pla_decode
// Description : Combinational C64 memory-map decode from address and banking.
// Revision    : 1.0 - initial release
// ============================================================================
module c64_pla_decode
    import c64_bus_pkg::*;
(
    input  logic [15:0] i_ab,
    input  logic [2:0]  i_po,
    input  logic        i_we,
    output region_t     o_region,
    output logic [1:0]  o_mem_sel
);

    logic    w_loram;
    logic    w_hiram;
    logic    w_charen;
    region_t w_map;

    assign w_loram  = i_po[0];
    assign w_hiram  = i_po[1];
    assign w_charen = i_po[2];

    always_comb begin
        w_map = REG_RAM;
        if (i_ab >= c_basic_base && i_ab < c_basic_end) begin
            if (w_loram && w_hiram) w_map = REG_BASIC;
        end else if (i_ab >= c_io_base && i_ab < c_kernal_base) begin
            if (w_loram || w_hiram) w_map = w_charen ? REG_IO : REG_CHAR;
        end else if (i_ab >= c_kernal_base) begin
            if (w_hiram) w_map = REG_KERNAL;
        end
    end

    // ROM is write-through to the RAM underneath it
    always_comb begin
        o_region = w_map;
        if (i_we && (w_map == REG_BASIC || w_map == REG_KERNAL || w_map == REG_CHAR))
            o_region = REG_RAM;
        case (o_region)
            REG_BASIC:  o_mem_sel = 2'd1;
            REG_KERNAL: o_mem_sel = 2'd2;
            REG_CHAR:   o_mem_sel = 2'd3;
            default:    o_mem_sel = 2'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/c64_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : c64_bus_responder
// Description : CPU bus target: decode, memory-port FSM with RDY stall, I/O.
// Revision    : 1.0 - initial release
// ============================================================================
module c64_bus_responder
    import c64_bus_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    c64_bus_responder_if.slave    bus
);

    region_t    w_region;
    logic [1:0] w_mem_sel;
    logic       w_is_io;
    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_latch;
    logic       w_load;
    logic       w_mem_req;
    logic       w_rdy;
    logic       w_io_we;
    logic [7:0] w_din;

    c64_pla_decode u_decode (
        .i_ab      (bus.ab),
        .i_po      (bus.po),
        .i_we      (bus.we),
        .o_region  (w_region),
        .o_mem_sel (w_mem_sel)
    );

    assign w_is_io = (w_region == REG_IO);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_latch <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (w_load) r_latch <= bus.mem_rdata;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_mem_req    = 1'b0;
        w_rdy        = 1'b0;
        w_io_we      = 1'b0;
        w_din        = r_latch;
        case (r_state)
            ST_IDLE: begin
                if (w_is_io) begin
                    w_rdy   = bus.ext_rdy;
                    w_din   = bus.io_rdata;
                    w_io_we = bus.we & bus.ext_rdy;
                end else begin
                    w_mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        w_load       = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_load       = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_rdy = bus.ext_rdy;
                if (bus.ext_rdy) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Reset cycle kills any strobe regardless of state
        if (!reset_n) begin
            w_mem_req = 1'b0;
            w_rdy     = 1'b0;
            w_io_we   = 1'b0;
        end
    end

    assign bus.din       = w_din;
    assign bus.rdy       = w_rdy;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = bus.we;
    assign bus.mem_sel   = w_mem_sel;
    assign bus.mem_addr  = bus.ab;
    assign bus.mem_wdata = bus.dout;
    assign bus.io_cs     = w_is_io;
    assign bus.io_we     = w_io_we;
    assign bus.io_addr   = bus.ab[11:0];
    assign bus.io_wdata  = bus.dout;

endmodule
`default_nettype wire

// File: tb/tb_c64_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_c64_bus_responder
// Description : Directed bench for c64_bus_responder with expected-read queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c64_bus_responder;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] din;
    } exp_t;
    exp_t q[$];

    c64_bus_responder_if bus ();

    c64_bus_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One memory access with ext_rdy high; ack arrives dly cycles after the request
    task automatic mem_access(input string tag, input logic [15:0] a, input logic w,
                              input logic [7:0] wd, input logic [2:0] p,
                              input logic [1:0] esel, input int dly, input logic [7:0] rd);
        exp_t e;
        int   low;
        e.sel = esel;
        e.din = rd;
        q.push_back(e);
        bus.ab = a; bus.we = w; bus.dout = wd; bus.po = p; bus.ext_rdy = 1'b1;
        low = 0;
        for (int k = 0; k <= dly; k++) begin
            bus.mem_ack   = (k == dly);
            bus.mem_rdata = (k == dly) ? rd : ~rd;
            #1;
            if (k == 0) begin
                chk({tag, "_we"},    {31'd0, bus.mem_we}, {31'd0, w});
                chk({tag, "_addr"},  {16'd0, bus.mem_addr}, {16'd0, a});
                chk({tag, "_wdata"}, {24'd0, bus.mem_wdata}, {24'd0, wd});
                chk({tag, "_iocs"},  {31'd0, bus.io_cs}, 32'd0);
            end
            chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
            if (!bus.rdy) low++;
            tick();
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        #1;
        e = q.pop_front();
        chk({tag, "_sel"},     {30'd0, bus.mem_sel}, {30'd0, e.sel});
        chk({tag, "_din"},     {24'd0, bus.din}, {24'd0, e.din});
        chk({tag, "_rdy"},     {31'd0, bus.rdy}, 32'd1);
        chk({tag, "_reqdone"}, {31'd0, bus.mem_req}, 32'd0);
        chk({tag, "_stall"},   low, dly + 1);
        tick();
    endtask

    initial begin
        exp_t e;
        int   reqs;
        total = 0;
        bad   = 0;

        // Reset with an I/O address on the bus
        reset_n = 1'b0;
        bus.ab = 16'hD020; bus.we = 1'b0; bus.dout = 8'h00; bus.po = 3'b111;
        bus.ext_rdy = 1'b1; bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00; bus.io_rdata = 8'h3C;
        #1;
        chk("rst_rdy",   {31'd0, bus.rdy}, 32'd0);
        chk("rst_req",   {31'd0, bus.mem_req}, 32'd0);
        chk("rst_io_we", {31'd0, bus.io_we}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // I/O write then read, zero wait states
        bus.ab = 16'hD020; bus.we = 1'b1; bus.dout = 8'h55;
        #1;
        chk("io_cs",    {31'd0, bus.io_cs}, 32'd1);
        chk("io_addr",  {20'd0, bus.io_addr}, 32'h020);
        chk("io_we",    {31'd0, bus.io_we}, 32'd1);
        chk("io_wdata", {24'd0, bus.io_wdata}, 32'h55);
        chk("io_rdy",   {31'd0, bus.rdy}, 32'd1);
        chk("io_noreq", {31'd0, bus.mem_req}, 32'd0);
        tick();
        bus.ab = 16'hDC01; bus.we = 1'b0; bus.io_rdata = 8'h7E;
        #1;
        chk("io_rd_we",  {31'd0, bus.io_we}, 32'd0);
        chk("io_rd_din", {24'd0, bus.din}, 32'h7E);
        chk("io_rd_req", {31'd0, bus.mem_req}, 32'd0);
        tick();
        bus.ab = 16'hD400; bus.we = 1'b1; bus.dout = 8'h0F; bus.ext_rdy = 1'b0;
        #1;
        chk("io_stall_we",  {31'd0, bus.io_we}, 32'd0);
        chk("io_stall_rdy", {31'd0, bus.rdy}, 32'd0);
        tick();
        bus.ext_rdy = 1'b1;
        #1;
        chk("io_resume_we", {31'd0, bus.io_we}, 32'd1);
        tick();
        bus.ab = 16'hD000; bus.we = 1'b0; bus.po = 3'b110;
        #1;
        chk("io_hiram_only", {31'd0, bus.io_cs}, 32'd1);
        tick();

        // Memory map and latency
        mem_access("kernal_rd",  16'hE000, 1'b0, 8'h00, 3'b111, 2'd2, 3, 8'h4C);
        mem_access("basic_rd",   16'hA000, 1'b0, 8'h00, 3'b111, 2'd1, 0, 8'h11);
        mem_access("ram_9fff",   16'h9FFF, 1'b0, 8'h00, 3'b111, 2'd0, 0, 8'h22);
        mem_access("ram_c000",   16'hC000, 1'b0, 8'h00, 3'b111, 2'd0, 1, 8'h33);
        mem_access("a000_nohi",  16'hA000, 1'b0, 8'h00, 3'b101, 2'd0, 0, 8'h44);
        mem_access("e000_nohi",  16'hE000, 1'b0, 8'h00, 3'b101, 2'd0, 0, 8'h45);
        mem_access("char_d000",  16'hD000, 1'b0, 8'h00, 3'b011, 2'd3, 1, 8'h66);
        mem_access("ram_d000",   16'hD000, 1'b0, 8'h00, 3'b000, 2'd0, 0, 8'h77);
        mem_access("char_dfff",  16'hDFFF, 1'b0, 8'h00, 3'b010, 2'd3, 0, 8'h78);
        mem_access("kern_ffff",  16'hFFFF, 1'b0, 8'h00, 3'b110, 2'd2, 2, 8'h79);
        mem_access("basic_wr",   16'hA123, 1'b1, 8'hAA, 3'b111, 2'd0, 0, 8'h88);
        mem_access("kernal_wr",  16'hE000, 1'b1, 8'h5A, 3'b111, 2'd0, 1, 8'h99);

        // Reset during WAIT abandons the request
        bus.ab = 16'h0400; bus.we = 1'b0; bus.po = 3'b111; bus.mem_ack = 1'b0;
        #1;
        chk("rw_idle_req", {31'd0, bus.mem_req}, 32'd1);
        tick();
        chk("rw_wait_req", {31'd0, bus.mem_req}, 32'd1);
        chk("rw_wait_rdy", {31'd0, bus.rdy}, 32'd0);
        reset_n = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
        #1;
        chk("rw_rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rw_rst_rdy", {31'd0, bus.rdy}, 32'd0);
        tick();
        reset_n = 1'b1; bus.mem_ack = 1'b0; bus.ab = 16'h0800;
        #1;
        chk("rw_fresh_req", {31'd0, bus.mem_req}, 32'd1);
        chk("rw_fresh_rdy", {31'd0, bus.rdy}, 32'd0);
        e.sel = 2'd0; e.din = 8'h12;
        q.push_back(e);
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h12;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
        #1;
        e = q.pop_front();
        chk("rw_fresh_din", {24'd0, bus.din}, {24'd0, e.din});
        chk("rw_fresh_rdy1", {31'd0, bus.rdy}, 32'd1);
        tick();

        // ext_rdy low for 5 cycles around a same-cycle-ack read
        bus.ab = 16'h0300; bus.we = 1'b0; bus.ext_rdy = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
        e.sel = 2'd0; e.din = 8'h5A;
        q.push_back(e);
        #1;
        chk("er_req0", {31'd0, bus.mem_req}, 32'd1);
        chk("er_rdy0", {31'd0, bus.rdy}, 32'd0);
        reqs = 1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            bus.mem_ack   = (c == 2);
            bus.mem_rdata = 8'hA5;
            #1;
            if (bus.mem_req) reqs++;
            chk("er_hold_rdy", {31'd0, bus.rdy}, 32'd0);
            chk("er_hold_din", {24'd0, bus.din}, 32'h5A);
            tick();
        end
        bus.ext_rdy = 1'b1; bus.mem_ack = 1'b0;
        #1;
        e = q.pop_front();
        chk("er_rdy", {31'd0, bus.rdy}, 32'd1);
        chk("er_din", {24'd0, bus.din}, {24'd0, e.din});
        chk("er_reqs", reqs, 1);
        tick();
        bus.ab = 16'hD011; bus.io_rdata = 8'h1B;
        #1;
        chk("er_back_idle", {24'd0, bus.din}, 32'h1B);
        chk("q_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/c64_bus_responder.md
# c64_bus_responder

Target side of the `cpu6510` bus. Decodes each CPU access (address, write enable, write data, processor-port banking bits) into the C64 memory map. Reads and writes are served from one variable-latency external memory port (RAM, BASIC, KERNAL, CHAR ROM) or a single-cycle I/O port. The block returns read data, and stalls the CPU through `rdy` until slow accesses complete.

## Interface
- No parameters.
- `clk` input 1: CPU clock.
- `reset_n` input 1: synchronous, active-low reset.
- `ab` input 16: CPU address (registered `AB` from `cpu6510`), stable while `rdy`=0.
- `we` input 1: CPU write enable, same timing as `ab`.
- `dout` input 8: CPU write data (`DO`).
- `po` input 3: processor port bits: [0] LORAM, [1] HIRAM, [2] CHAREN.
- `ext_rdy` input 1: external stall request (VIC-II); 0 = hold CPU.
- `din` output 8: read data to CPU (`DI`).
- `rdy` output 1: to CPU `RDY`.
- `mem_req` output 1: memory request, held until `mem_ack`.
- `mem_we` output 1: memory write.
- `mem_sel` output 2: 0 RAM, 1 BASIC, 2 KERNAL, 3 CHAR.
- `mem_addr` output 16: equals `ab`.
- `mem_wdata` output 8: equals `dout`.
- `mem_ack` input 1: one-cycle completion pulse; `mem_rdata` is valid with it.
- `mem_rdata` input 8: memory read data.
- `io_cs` output 1: I/O region selected.
- `io_we` output 1: I/O write strobe, one cycle per write.
- `io_addr` output 12: `ab[11:0]`.
- `io_wdata` output 8: equals `dout`.
- `io_rdata` input 8: I/O read data, combinational from `io_addr`.

## Operation
- Region decode, combinational from `ab`/`po`/`we`:
  - $A000–$BFFF: BASIC if LORAM&HIRAM, else RAM.
  - $D000–$DFFF: RAM if LORAM=HIRAM=0; otherwise I/O if CHAREN=1, CHAR if CHAREN=0.
  - $E000–$FFFF: KERNAL if HIRAM, else RAM.
  - All other addresses: RAM.
- Writes to BASIC, KERNAL or CHAR regions go to RAM (`mem_sel`=0, `mem_we`=1). ROM is never written.
- FSM states: IDLE, WAIT, DONE.
- IDLE, I/O region:
  - `rdy`=`ext_rdy`; `din`=`io_rdata`; `io_we`=`we`&`ext_rdy`.
  - State stays IDLE.
- IDLE, memory region:
  - `mem_req`=1 and `rdy`=0.
  - If `mem_ack`=1 in the same cycle, latch `mem_rdata` and go to DONE; otherwise go to WAIT.
- WAIT:
  - `mem_req`=1, `rdy`=0.
  - On `mem_ack`, latch `mem_rdata` and go to DONE.
- DONE:
  - `mem_req`=0, `din`=latch, `rdy`=`ext_rdy`.
  - Go to IDLE at the edge where `ext_rdy`=1. While `ext_rdy`=0, stay in DONE; no new request is issued.
- `mem_sel`, `mem_we` and `mem_addr` stay stable while `mem_req`=1, because the CPU is stalled.
- `mem_ack` outside WAIT or IDLE-with-request is ignored.
- `ext_rdy`=0 in IDLE with a memory access: the request is still issued. Completion waits in DONE.
- Reset (`reset_n`=0):
  - State goes to IDLE; latch cleared to $00.
  - `mem_req`, `io_we` and `rdy` are forced to 0 in the reset cycle, whatever the state. An outstanding request is abandoned; the memory side discards its ack.
- `din` in IDLE with a memory region, or in WAIT: don't-care, driven as latch.

## Timing
- I/O access: zero wait states; `rdy` follows `ext_rdy`.
- Memory access: one wait cycle minimum. Total cycles = 2 + (cycles from `mem_req` to `mem_ack`) when `ext_rdy`=1.
- Back-to-back memory accesses: a new request is issued in the first IDLE cycle after DONE, so the minimum cadence is 2 cycles per access.
- `rdy` is combinational from state, decode and `ext_rdy`. There is no path from `din`/`mem_rdata` to `rdy`.
- Banking change: a write to $0001 takes effect on the next access. `po` is sampled combinationally and only changes when `rdy`=1.

## Structure
- Package `c64_bus_pkg`:
  - region enum (RAM, BASIC, KERNAL, CHAR, IO);
  - FSM state enum;
  - region base constants ($A000, $D000, $E000).
- Sub-module `c64_pla_decode`: purely combinational, `ab`/`po`/`we` → region and `mem_sel`. Reused later by the VIC-II bus side.
- Top level holds the FSM, read-data latch and output muxing.

## Test plan
- `po`=3'b111, read $E000, `mem_ack` 3 cycles after `mem_req` → `mem_sel`=2; `rdy` is low 4 cycles; `din`=`mem_rdata` ($4C) in DONE.
- `po`=3'b111, write $55 to $D020 → `io_cs`=1, `io_addr`=$020, exactly one `io_we` pulse, `rdy`=1, `mem_req` never asserted.
- `po`=3'b101 (HIRAM=0), read $A000 and $E000 → `mem_sel`=0 both. `po`=3'b011 (CHAREN=0), read $D000 → `mem_sel`=3. `po`=3'b000, read $D000 → `mem_sel`=0.
- Write $AA to $A123 with BASIC banked in → `mem_sel`=0, `mem_we`=1, `mem_wdata`=$AA.
- `ext_rdy` low 5 cycles spanning a memory read with same-cycle ack → one `mem_req` cycle total; the FSM holds DONE until `ext_rdy`=1; `din` is stable throughout.
- `reset_n` low during WAIT → next cycle IDLE, `mem_req`=0, `rdy`=0. After release, a read of $0800 issues a fresh request.
